// File: rtl/performance_counters.sv
// Free-running performance counters: enabled cycles, retired instructions and one counter per event line.
// Build macro PERFCNT_SATURATE_EN makes every counter stick at all-ones instead of wrapping to zero.
module performance_counters #(
   parameter int COUNTER_WIDTH = 32,
   parameter int NUM_EVENTS    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     instruction_retired,
   input  logic                     cycle_count_en,
   input  logic [NUM_EVENTS-1:0]    event_signals,
   output logic [COUNTER_WIDTH-1:0] cycle_count,
   output logic [COUNTER_WIDTH-1:0] instret_count,
   output logic [COUNTER_WIDTH-1:0] event_counts [0:NUM_EVENTS-1]
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};

   // Single point where wrap-versus-saturate is decided for every counter.
   function automatic logic [COUNTER_WIDTH-1:0] next_count(
      input logic [COUNTER_WIDTH-1:0] cur,
      input logic                     inc
   );
      logic [COUNTER_WIDTH-1:0] result;
      result = cur;
      if (inc) begin
`ifdef PERFCNT_SATURATE_EN
         if (cur == CNT_MAX) begin
            result = cur;
         end else begin
            result = cur + CNT_ONE;
         end
`else
         result = cur + CNT_ONE;
`endif
      end else begin
         result = cur;
      end
      return result;
   endfunction

   logic [COUNTER_WIDTH-1:0] cycle_count_r;
   logic [COUNTER_WIDTH-1:0] cycle_count_s;
   logic [COUNTER_WIDTH-1:0] instret_count_r;
   logic [COUNTER_WIDTH-1:0] instret_count_s;
   logic [COUNTER_WIDTH-1:0] event_count_r [0:NUM_EVENTS-1];
   logic [COUNTER_WIDTH-1:0] event_count_s [0:NUM_EVENTS-1];

   // Next values for the cycle and instret counters.
   always_comb begin
      cycle_count_s   = next_count(cycle_count_r, cycle_count_en);
      instret_count_s = next_count(instret_count_r, instruction_retired);
   end

   // Next values for the event counters; each bit is independent of the others.
   always_comb begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
         event_count_s[i] = next_count(event_count_r[i], event_signals[i]);
      end
   end

   // Counter state; reset wins over any increment on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count_r   <= CNT_ZERO;
         instret_count_r <= CNT_ZERO;
         for (int i = 0; i < NUM_EVENTS; i++) begin
            event_count_r[i] <= CNT_ZERO;
         end
      end else begin
         cycle_count_r   <= cycle_count_s;
         instret_count_r <= instret_count_s;
         for (int i = 0; i < NUM_EVENTS; i++) begin
            event_count_r[i] <= event_count_s[i];
         end
      end
   end

   assign cycle_count   = cycle_count_r;
   assign instret_count = instret_count_r;
   assign event_counts  = event_count_r;

endmodule

// File: tb/tb_performance_counters.sv
// Randomised and directed bench for performance_counters against an unbounded-integer reference model.
module tb_performance_counters;

   logic        clk;
   logic        reset;
   logic        instruction_retired;
   logic        cycle_count_en;
   logic [31:0] event_signals;
   logic [31:0] cyc_out;
   logic [31:0] ret_out;
   logic [31:0] ev_out [0:31];
   logic [7:0]  cyc8_out;
   logic [7:0]  ret8_out;
   logic [7:0]  ev8_out [0:3];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: true event totals since the last reset, never truncated.
   longint unsigned cyc_n;
   longint unsigned ret_n;
   longint unsigned ev_n [0:31];

   performance_counters #(.COUNTER_WIDTH(32), .NUM_EVENTS(32)) dut (
      .clk(clk), .reset(reset), .instruction_retired(instruction_retired),
      .cycle_count_en(cycle_count_en), .event_signals(event_signals),
      .cycle_count(cyc_out), .instret_count(ret_out), .event_counts(ev_out)
   );

   performance_counters #(.COUNTER_WIDTH(8), .NUM_EVENTS(4)) dut8 (
      .clk(clk), .reset(reset), .instruction_retired(instruction_retired),
      .cycle_count_en(cycle_count_en), .event_signals(event_signals[3:0]),
      .cycle_count(cyc8_out), .instret_count(ret8_out), .event_counts(ev8_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint unsigned exp_val(input longint unsigned n, input int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 64'd1;
`ifdef PERFCNT_SATURATE_EN
      return (n > mx) ? mx : n;
`else
      return n & mx;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      if (reset) begin
         cyc_n = 0; ret_n = 0;
         for (int i = 0; i < 32; i++) ev_n[i] = 0;
      end else begin
         if (cycle_count_en) cyc_n++;
         if (instruction_retired) ret_n++;
         for (int i = 0; i < 32; i++) if (event_signals[i]) ev_n[i]++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      instruction_retired = 1'b0;
      cycle_count_en      = 1'b0;
      event_signals       = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      for (int k = 0; k < 10; k++) step();
      total_cnt++;
      if (cyc_out !== 32'd0) $display("FAIL reset_cycle got %0d want 0", cyc_out); else pass_cnt++;
      total_cnt++;
      if (ret_out !== 32'd0) $display("FAIL reset_instret got %0d want 0", ret_out); else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         total_cnt++;
         if (ev_out[i] !== 32'd0) $display("FAIL reset_event%0d got %0d want 0", i, ev_out[i]); else pass_cnt++;
      end
      reset = 1'b0;
      cycle_count_en = 1'b1;
      for (int k = 0; k < 15; k++) step();
      total_cnt++;
      if (cyc_out !== 32'd15) $display("FAIL cycle15 got %0d want 15", cyc_out); else pass_cnt++;
      total_cnt++;
      if (ret_out !== 32'd0) $display("FAIL cycle15_instret got %0d want 0", ret_out); else pass_cnt++;
   endtask

   task automatic test_instret();
      do_reset();
      cycle_count_en = 1'b1;
      instruction_retired = 1'b1;
      for (int k = 0; k < 10; k++) step();
      instruction_retired = 1'b0;
      for (int k = 0; k < 5; k++) step();
      total_cnt++;
      if (ret_out !== 32'd10) $display("FAIL instret10 got %0d want 10", ret_out); else pass_cnt++;
      total_cnt++;
      if (cyc_out !== 32'd15) $display("FAIL instret_cycle got %0d want 15", cyc_out); else pass_cnt++;
   endtask

   task automatic test_events();
      do_reset();
      event_signals = 32'h3;
      for (int k = 0; k < 3; k++) step();
      event_signals = 32'h1;
      for (int k = 0; k < 2; k++) step();
      event_signals = 32'h0;
      step();
      total_cnt++;
      if (ev_out[0] !== 32'd5) $display("FAIL event0 got %0d want 5", ev_out[0]); else pass_cnt++;
      total_cnt++;
      if (ev_out[1] !== 32'd3) $display("FAIL event1 got %0d want 3", ev_out[1]); else pass_cnt++;
      for (int i = 2; i < 32; i++) begin
         total_cnt++;
         if (ev_out[i] !== 32'd0) $display("FAIL event%0d got %0d want 0", i, ev_out[i]); else pass_cnt++;
      end
      total_cnt++;
      if (cyc_out !== 32'd0) $display("FAIL event_cycle got %0d want 0", cyc_out); else pass_cnt++;
   endtask

   task automatic test_gate();
      do_reset();
      cycle_count_en = 1'b1;
      for (int k = 0; k < 3; k++) step();
      cycle_count_en = 1'b0;
      instruction_retired = 1'b1;
      for (int k = 0; k < 4; k++) step();
      total_cnt++;
      if (cyc_out !== 32'd3) $display("FAIL gate_cycle got %0d want 3", cyc_out); else pass_cnt++;
      total_cnt++;
      if (ret_out !== 32'd4) $display("FAIL gate_instret got %0d want 4", ret_out); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [7:0] want8;
      do_reset();
      cycle_count_en = 1'b1;
      event_signals  = 32'h1;
      for (int k = 0; k < 256; k++) step();
`ifdef PERFCNT_SATURATE_EN
      want8 = 8'd255;
`else
      want8 = 8'd0;
`endif
      total_cnt++;
      if (cyc8_out !== want8) $display("FAIL wrap_cycle8 got %0d want %0d", cyc8_out, want8); else pass_cnt++;
      total_cnt++;
      if (ev8_out[0] !== want8) $display("FAIL wrap_event8 got %0d want %0d", ev8_out[0], want8); else pass_cnt++;
      total_cnt++;
      if (cyc_out !== 32'd256) $display("FAIL wrap_cycle32 got %0d want 256", cyc_out); else pass_cnt++;
      for (int k = 0; k < 10; k++) step();
`ifdef PERFCNT_SATURATE_EN
      want8 = 8'd255;
`else
      want8 = 8'd10;
`endif
      total_cnt++;
      if (cyc8_out !== want8) $display("FAIL wrap_cycle8_after got %0d want %0d", cyc8_out, want8); else pass_cnt++;
      total_cnt++;
      if (ret8_out !== 8'd0) $display("FAIL wrap_instret8 got %0d want 0", ret8_out); else pass_cnt++;
   endtask

   task automatic test_reset_override();
      do_reset();
      cycle_count_en = 1'b1;
      instruction_retired = 1'b1;
      event_signals = 32'hFFFF_FFFF;
      for (int k = 0; k < 6; k++) step();
      reset = 1'b1;
      step();
      total_cnt++;
      if (cyc_out !== 32'd0) $display("FAIL ovr_cycle got %0d want 0", cyc_out); else pass_cnt++;
      total_cnt++;
      if (ret_out !== 32'd0) $display("FAIL ovr_instret got %0d want 0", ret_out); else pass_cnt++;
      total_cnt++;
      if (ev_out[31] !== 32'd0) $display("FAIL ovr_event31 got %0d want 0", ev_out[31]); else pass_cnt++;
      reset = 1'b0;
      step();
      total_cnt++;
      if (cyc_out !== 32'd1) $display("FAIL resume_cycle got %0d want 1", cyc_out); else pass_cnt++;
      total_cnt++;
      if (ret_out !== 32'd1) $display("FAIL resume_instret got %0d want 1", ret_out); else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         total_cnt++;
         if (ev_out[i] !== 32'd1) $display("FAIL resume_event%0d got %0d want 1", i, ev_out[i]); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         reset               = ($urandom_range(0, 39) == 0);
         cycle_count_en      = 1'($urandom);
         instruction_retired = 1'($urandom);
         event_signals       = $urandom;
         step();
         total_cnt++;
         if (64'(cyc_out) !== exp_val(cyc_n, 32)) $display("FAIL rnd_cycle t=%0d got %0d want %0d", k, cyc_out, exp_val(cyc_n, 32)); else pass_cnt++;
         total_cnt++;
         if (64'(ret_out) !== exp_val(ret_n, 32)) $display("FAIL rnd_instret t=%0d got %0d want %0d", k, ret_out, exp_val(ret_n, 32)); else pass_cnt++;
         for (int i = 0; i < 32; i++) begin
            total_cnt++;
            if (64'(ev_out[i]) !== exp_val(ev_n[i], 32)) $display("FAIL rnd_event%0d t=%0d got %0d want %0d", i, k, ev_out[i], exp_val(ev_n[i], 32)); else pass_cnt++;
         end
         total_cnt++;
         if (64'(cyc8_out) !== exp_val(cyc_n, 8)) $display("FAIL rnd_cycle8 t=%0d got %0d want %0d", k, cyc8_out, exp_val(cyc_n, 8)); else pass_cnt++;
         total_cnt++;
         if (64'(ret8_out) !== exp_val(ret_n, 8)) $display("FAIL rnd_instret8 t=%0d got %0d want %0d", k, ret8_out, exp_val(ret_n, 8)); else pass_cnt++;
         for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (64'(ev8_out[i]) !== exp_val(ev_n[i], 8)) $display("FAIL rnd_event8_%0d t=%0d got %0d want %0d", i, k, ev8_out[i], exp_val(ev_n[i], 8)); else pass_cnt++;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      cyc_n = 0; ret_n = 0;
      for (int i = 0; i < 32; i++) ev_n[i] = 0;
      test_reset();
      test_instret();
      test_events();
      test_gate();
      test_wrap();
      test_reset_override();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/performance_counters.md
PERFORMANCE_COUNTERS -- requirements
Module: performance_counters

Interface
REQ-001 Parameter COUNTER_WIDTH, default 32: bit width of every counter.
REQ-002 Parameter NUM_EVENTS, default 32: number of event inputs and event counters.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 instruction_retired  input  1  one instruction retired this cycle.
REQ-007 cycle_count_en  input  1  enables the cycle counter.
REQ-008 event_signals  input  NUM_EVENTS  bit i high = event i occurred this cycle.
REQ-009 cycle_count  output  COUNTER_WIDTH  elapsed enabled cycles.
REQ-010 instret_count  output  COUNTER_WIDTH  retired instructions.
REQ-011 event_counts  output  unpacked array [0:NUM_EVENTS-1] of COUNTER_WIDTH  per-event occurrence counts.

Function
REQ-012 All counters SHALL be registers updated only on the rising edge of clk; outputs drive the registers directly, with no combinational path from inputs.
REQ-013 cycle_count SHALL increment by 1 on every edge where cycle_count_en=1, and hold otherwise.
REQ-014 instret_count SHALL increment by 1 on every edge where instruction_retired=1, independent of cycle_count_en.
REQ-015 event_counts[i] SHALL increment by 1 on every edge where event_signals[i]=1, independent of cycle_count_en and of other bits.
REQ-016 Simultaneous assertion of any inputs SHALL update all affected counters in the same cycle, with no priority or interaction.
REQ-017 Latency: an input sampled high at edge N SHALL be reflected in the output after edge N.
REQ-018 Increment is +1 per cycle maximum. A level held high for K cycles SHALL add exactly K.
REQ-019 Overflow without the configuration macro: counters wrap modulo 2^COUNTER_WIDTH, so all-ones +1 becomes 0.
REQ-020 Inputs SHALL be treated as synchronous to clk; the block adds no synchronizers or edge detection.

Reset
REQ-021 When reset=1 at a rising edge, cycle_count, instret_count and all event_counts SHALL become 0, overriding any increment.
REQ-022 Reset asserted mid-count SHALL clear counters on that edge. Counting SHALL resume on the first edge with reset=0.
REQ-023 No asynchronous behaviour; before the first reset edge, values are undefined.

Configuration
REQ-024 Macro PERFCNT_SATURATE_EN: when defined, every counter SHALL saturate at all-ones and hold there until reset.
REQ-025 When PERFCNT_SATURATE_EN is undefined, counters SHALL wrap as per REQ-019.
REQ-026 The macro SHALL NOT change ports, reset behaviour or latency.

Verification
REQ-027 Reset held 10 cycles with all inputs 0 -> all outputs 0; then cycle_count_en=1 for 15 cycles with reset=0 -> cycle_count=15.
REQ-028 cycle_count_en=1 and instruction_retired=1 for 10 cycles, then instruction_retired=0 for 5 -> instret_count=10, cycle_count=15.
REQ-029 event_signals=0x3 for 3 cycles, then 0x1 for 2, then 0 -> event_counts[0]=5, event_counts[1]=3, event_counts[2..31]=0.
REQ-030 cycle_count_en=0 while instruction_retired=1 for 4 cycles -> cycle_count unchanged, instret_count +4.
REQ-031 COUNTER_WIDTH=8, cycle_count_en=1 for 256 cycles -> cycle_count=0 without the macro; 255 with PERFCNT_SATURATE_EN, and 255 after a further 10 cycles.
REQ-032 reset=1 for one cycle while all inputs are high and counters are non-zero -> all outputs 0 after that edge, and 1 after the next edge with inputs still high.
